// File: rtl/dec_key_sched_ctrl.sv
// Decryption key-schedule sequencer: loads the final-round key state and streams
// round keys ROUNDS..0 over valid/ready, stepping the external key-update datapath once per transfer.
module dec_key_sched_ctrl #(
    parameter int ROUNDS = 25,
    parameter int KEY_W  = 80,
    parameter int RK_W   = 64,
    parameter int RND_W  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [KEY_W-1:0] i_last_key,
    output logic [KEY_W-1:0] o_ks_oldkey,
    output logic [RND_W-1:0] o_round_counter,
    input  logic [KEY_W-1:0] i_ks_newkey,
    output logic             o_rk_valid,
    input  logic             i_rk_ready,
    output logic [RK_W-1:0]  o_round_key,
    output logic [RND_W-1:0] o_rk_round,
    output logic             o_busy,
    output logic             o_done
);

    localparam logic [RND_W-1:0] FIRST_RND = RND_W'(ROUNDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [KEY_W-1:0]   key_q, key_d;
    logic [RND_W-1:0]   rnd_q, rnd_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            key_q   <= '0;
            rnd_q   <= '0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            rnd_q   <= rnd_d;
        end
    end

    // Abort wins over start and transfer; round 0 transfer leaves key/round untouched.
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        rnd_d   = rnd_q;
        if (i_abort) begin
            state_d = IDLE;
            key_d   = '0;
            rnd_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_start) begin
                        key_d   = i_last_key;
                        rnd_d   = FIRST_RND;
                        state_d = EMIT;
                    end
                end
                EMIT: begin
                    if (i_rk_ready) begin
                        if (rnd_q == '0) begin
                            state_d = DONE;
                        end else begin
                            key_d = i_ks_newkey;
                            rnd_d = rnd_q - 1'b1;
                        end
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // All outputs are decoded from registers only, so nothing combinational reaches them from ready.
    assign o_ks_oldkey     = key_q;
    assign o_round_counter = rnd_q;
    assign o_round_key     = key_q[KEY_W-1 -: RK_W];
    assign o_rk_round      = rnd_q;
    assign o_rk_valid      = (state_q == EMIT);
    assign o_busy          = (state_q == EMIT);
    assign o_done          = (state_q == DONE);

endmodule

// File: tb/tb_dec_key_sched_ctrl.sv
// Self-checking bench for dec_key_sched_ctrl: a table-driven key-sequence model checked every cycle,
// plus directed scenarios (reset, full run, backpressure, abort, ignored start, async reset).
module tb_dec_key_sched_ctrl;

    localparam int ROUNDS = 25;
    localparam logic [79:0] K0 = 80'h0123_4567_89AB_CDEF_0123;
    localparam logic [79:0] K1 = 80'hFEDC_BA98_7654_3210_A5A5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_start = 1'b0;
    logic        i_abort = 1'b0;
    logic [79:0] i_last_key = '0;
    logic [79:0] o_ks_oldkey;
    logic [4:0]  o_round_counter;
    logic [79:0] i_ks_newkey;
    logic        o_rk_valid;
    logic        i_rk_ready = 1'b0;
    logic [63:0] o_round_key;
    logic [4:0]  o_rk_round;
    logic        o_busy;
    logic        o_done;

    int n_checks = 0;
    int n_fail   = 0;
    int n_xfer   = 0;
    int n_done   = 0;

    always #5 clk = ~clk;

    dec_key_sched_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .i_start         (i_start),
        .i_abort         (i_abort),
        .i_last_key      (i_last_key),
        .o_ks_oldkey     (o_ks_oldkey),
        .o_round_counter (o_round_counter),
        .i_ks_newkey     (i_ks_newkey),
        .o_rk_valid      (o_rk_valid),
        .i_rk_ready      (i_rk_ready),
        .o_round_key     (o_round_key),
        .o_rk_round      (o_rk_round),
        .o_busy          (o_busy),
        .o_done          (o_done)
    );

    // Stand-in key-update datapath: rotate and mix in the round index.
    function automatic logic [79:0] ks_f(input logic [79:0] k, input logic [4:0] r);
        return {k[18:0], k[79:19]} ^ {75'd0, r};
    endfunction

    // Key state expected while round rnd is presented, derived from the loaded key.
    function automatic logic [79:0] exp_key(input logic [79:0] last, input int rnd);
        logic [79:0] k;
        k = last;
        for (int r = ROUNDS; r > rnd; r--) k = ks_f(k, 5'(r));
        return k;
    endfunction

    assign i_ks_newkey = ks_f(o_ks_oldkey, o_round_counter);

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: phase 0 idle, 1 emitting, 2 done pulse.
    int          m_phase = 0;
    int          m_rnd = 0;
    logic [79:0] m_last = '0;
    bit          m_cleared = 1'b1;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_phase <= 0; m_rnd <= 0; m_cleared <= 1'b1;
        end else if (i_abort) begin
            m_phase <= 0; m_rnd <= 0; m_cleared <= 1'b1;
        end else if (m_phase == 0) begin
            if (i_start) begin
                m_phase <= 1; m_rnd <= ROUNDS; m_last <= i_last_key; m_cleared <= 1'b0;
            end
        end else if (m_phase == 1) begin
            if (i_rk_ready) begin
                if (m_rnd == 0) m_phase <= 2;
                else m_rnd <= m_rnd - 1;
            end
        end else begin
            m_phase <= 0;
        end
    end

    initial forever begin
        logic [79:0] ek;
        @(negedge clk);
        ek = m_cleared ? 80'd0 : exp_key(m_last, m_rnd);
        chk("valid", {79'd0, o_rk_valid}, {79'd0, m_phase == 1});
        chk("busy",  {79'd0, o_busy},     {79'd0, m_phase == 1});
        chk("done",  {79'd0, o_done},     {79'd0, m_phase == 2});
        chk("oldkey", o_ks_oldkey, ek);
        chk("round_counter", {75'd0, o_round_counter}, 80'(m_rnd));
        if (m_phase == 1) begin
            chk("round_key", {16'd0, o_round_key}, {16'd0, ek[79:16]});
            chk("rk_round", {75'd0, o_rk_round}, 80'(m_rnd));
        end
    end

    initial forever begin
        @(posedge clk);
        if (o_rk_valid && i_rk_ready) n_xfer++;
        if (o_done) n_done++;
    end

    // Starts a run at the current negedge and follows it to o_done.
    task automatic run_seq(input logic [79:0] key, input bit rand_ready, input int poke_round,
                           output int cycles, output logic [63:0] first_rk);
        int  x0, d0;
        bit  got, poked;
        x0 = n_xfer; d0 = n_done; got = 0; poked = 0; cycles = 0; first_rk = '0;
        i_last_key = key; i_start = 1'b1;
        i_rk_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        while (cycles < 300 && !got) begin
            @(negedge clk);
            cycles++;
            i_start = 1'b0;
            if (cycles == 1) begin
                first_rk = o_round_key;
                chk("first_round", {75'd0, o_rk_round}, 80'd25);
            end
            if (o_done) got = 1;
            else begin
                if (o_rk_valid && o_rk_round == 5'(poke_round) && !poked) begin
                    i_start = 1'b1; i_last_key = K1; poked = 1;
                end
                i_rk_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end
        chk("run_finished", {79'd0, got}, 80'd1);
        @(negedge clk);
        chk("done_one_cycle", {79'd0, o_done}, 80'd0);
        chk("xfer_count", 80'(n_xfer - x0), 80'd26);
        chk("done_count", 80'(n_done - d0), 80'd1);
    endtask

    task automatic start_and_wait(input logic [79:0] key, input int rnd);
        bit hit;
        hit = 0;
        i_last_key = key; i_start = 1'b1; i_rk_ready = 1'b1;
        for (int c = 0; c < 100 && !hit; c++) begin
            @(negedge clk);
            i_start = 1'b0;
            if (o_rk_valid && o_rk_round == 5'(rnd)) hit = 1;
        end
        chk("reached_round", {79'd0, hit}, 80'd1);
    endtask

    initial begin
        int cyc;
        int d0;
        logic [63:0] frk;

        // Reset held with start asserted.
        #1 rst = 1'b0;
        i_start = 1'b1; i_last_key = K0;
        repeat (3) @(negedge clk);
        chk("rst_valid", {79'd0, o_rk_valid}, 80'd0);
        chk("rst_round_key", {16'd0, o_round_key}, 80'd0);
        rst = 1'b1; i_start = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_after_rst", {79'd0, o_rk_valid}, 80'd0);

        // Full run, ready held high.
        run_seq(K0, 1'b0, -1, cyc, frk);
        chk("first_rk_literal", {16'd0, frk}, {16'd0, 64'h0123_4567_89AB_CDEF});
        chk("done_cycle", 80'(cyc), 80'd27);

        // Backpressure.
        run_seq(K0, 1'b1, -1, cyc, frk);
        chk("bp_first_rk", {16'd0, frk}, {16'd0, 64'h0123_4567_89AB_CDEF});

        // Start pulsed mid-run with another key.
        run_seq(K0, 1'b0, 20, cyc, frk);
        chk("poke_done_cycle", 80'(cyc), 80'd27);

        // Abort at round 12 together with start.
        start_and_wait(K0, 12);
        d0 = n_done;
        i_abort = 1'b1; i_start = 1'b1;
        @(negedge clk);
        i_abort = 1'b0; i_start = 1'b0;
        chk("abort_valid", {79'd0, o_rk_valid}, 80'd0);
        repeat (3) @(negedge clk);
        chk("abort_no_done", 80'(n_done - d0), 80'd0);
        run_seq(K0, 1'b0, -1, cyc, frk);
        chk("restart_first_rk", {16'd0, frk}, {16'd0, 64'h0123_4567_89AB_CDEF});

        // Async reset between edges at round 7.
        start_and_wait(K0, 7);
        d0 = n_done;
        #2 rst = 1'b0;
        #1;
        chk("arst_valid", {79'd0, o_rk_valid}, 80'd0);
        chk("arst_busy", {79'd0, o_busy}, 80'd0);
        chk("arst_oldkey", o_ks_oldkey, 80'd0);
        chk("arst_round", {75'd0, o_round_counter}, 80'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        chk("arst_no_done", 80'(n_done - d0), 80'd0);
        chk("arst_idle", {79'd0, o_rk_valid}, 80'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
